chord_voice_allocator: RTL and testbench

Voice allocation and duration scheduler for the chord synthesis path. It accepts single-cycle note events (note code plus duration in beats) and assigns each to the lowest-index free voice of the chord player. It counts each voice's remaining duration on `beat` while `play` is high and frees the voice when the count expires. Downstream note players take `voice_load`, `voice_note` and `voice_active` as their per-voice controls.

---
 rtl/chord_voice_allocator.sv | 145 ++++++++++++++
 tb/tb_chord_voice_allocator.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chord_voice_allocator.sv
// chord_voice_allocator: voice allocation and beat-duration scheduler for the
// chord synthesis path. Note events are assigned to the lowest-index free
// voice; each voice counts its remaining beats while play is high and is
// released when the count runs out.
//
// Optional feature macro: VOICE_STEAL_EN
//   defined   - with no free voice, the note steals the active voice with the
//               smallest remaining count (lowest index on a tie); dropped is 0.
//   undefined - with no free voice, the note is discarded and dropped pulses.
module chord_voice_allocator #(
    parameter int NVOICES = 3,
    parameter int NOTE_W  = 6,
    parameter int DUR_W   = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      play,
    input  logic [NOTE_W-1:0]         note,
    input  logic [DUR_W-1:0]          duration,
    input  logic                      new_note,
    input  logic                      beat,
    output logic [NVOICES-1:0]        voice_load,
    output logic [NVOICES*NOTE_W-1:0] voice_note,
    output logic [NVOICES-1:0]        voice_active,
    output logic [NVOICES-1:0]        voice_done,
    output logic                      full,
    output logic                      dropped
);

    // Per-voice state
    logic [NVOICES-1:0] active;
    logic [DUR_W-1:0]   rem    [NVOICES];
    logic [NOTE_W-1:0]  note_r [NVOICES];

    // Event qualification: a beat only counts while playing, and a
    // zero-length note is not an allocation request at all.
    logic tick;
    logic req;
    assign tick = beat & play;
    assign req  = new_note & (duration != '0);

    // Lowest-index voice that was idle at the start of the cycle. A voice
    // expiring on this same edge is still active here, so it is never chosen.
    logic [NVOICES-1:0] free_sel;
    logic               free_any;
    always_comb begin
        free_sel = '0;
        free_any = 1'b0;
        for (int i = 0; i < NVOICES; i++) begin
            if (!active[i] && !free_any) begin
                free_sel[i] = 1'b1;
                free_any    = 1'b1;
            end
        end
    end

    // Choose which voice (if any) this cycle's request loads, and whether
    // the request is discarded.
    logic [NVOICES-1:0] load_vec;
    logic               drop_now;
`ifdef VOICE_STEAL_EN
    logic [NVOICES-1:0] steal_sel;
    logic [DUR_W-1:0]   min_rem;
    // Smallest remaining count wins; strict compare keeps the lowest index on ties.
    always_comb begin
        steal_sel = NVOICES'(1);
        min_rem   = rem[0];
        for (int i = 1; i < NVOICES; i++) begin
            if (rem[i] < min_rem) begin
                min_rem      = rem[i];
                steal_sel    = '0;
                steal_sel[i] = 1'b1;
            end
        end
    end

    // With stealing, a request always lands on some voice.
    always_comb begin
        load_vec = '0;
        drop_now = 1'b0;
        if (req) begin
            load_vec = free_any ? free_sel : steal_sel;
        end
    end
`else
    // Without stealing, a request with no free voice is discarded.
    always_comb begin
        load_vec = '0;
        drop_now = 1'b0;
        if (req) begin
            if (free_any) begin
                load_vec = free_sel;
            end else begin
                drop_now = 1'b1;
            end
        end
    end
`endif

    // Voice state update: a load takes priority and keeps its full duration;
    // otherwise a qualifying beat counts down and releases an expiring voice.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active     <= '0;
            voice_done <= '0;
            voice_load <= '0;
            dropped    <= 1'b0;
            for (int i = 0; i < NVOICES; i++) begin
                rem[i]    <= '0;
                note_r[i] <= '0;
            end
        end else begin
            voice_load <= load_vec;
            dropped    <= drop_now;
            for (int i = 0; i < NVOICES; i++) begin
                voice_done[i] <= 1'b0;
                if (load_vec[i]) begin
                    active[i] <= 1'b1;
                    rem[i]    <= duration;
                    note_r[i] <= note;
                end else if (tick && active[i]) begin
                    if (rem[i] == DUR_W'(1)) begin
                        active[i]     <= 1'b0;
                        rem[i]        <= '0;
                        voice_done[i] <= 1'b1;
                    end else if (rem[i] != '0) begin
                        rem[i] <= rem[i] - DUR_W'(1);
                    end
                end
            end
        end
    end

    // Output packing
    genvar g;
    generate
        for (g = 0; g < NVOICES; g++) begin : g_note
            assign voice_note[g*NOTE_W +: NOTE_W] = note_r[g];
        end
    endgenerate

    assign voice_active = active;
    assign full         = &active;

endmodule

// File: tb/tb_chord_voice_allocator.sv
// Directed testbench for chord_voice_allocator (default build, 3 voices).
module tb_chord_voice_allocator;

    localparam int NV = 3;
    localparam int NW = 6;
    localparam int DW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          play;
    logic [NW-1:0] note;
    logic [DW-1:0] duration;
    logic          new_note;
    logic          beat;
    logic [NV-1:0] voice_load;
    logic [NV*NW-1:0] voice_note;
    logic [NV-1:0] voice_active;
    logic [NV-1:0] voice_done;
    logic          full;
    logic          dropped;

    int total = 0;
    int bad   = 0;

    chord_voice_allocator #(.NVOICES(NV), .NOTE_W(NW), .DUR_W(DW)) dut (
        .clk(clk), .reset(reset), .play(play), .note(note), .duration(duration),
        .new_note(new_note), .beat(beat), .voice_load(voice_load),
        .voice_note(voice_note), .voice_active(voice_active),
        .voice_done(voice_done), .full(full), .dropped(dropped)
    );

    always #5 clk = ~clk;

    // advance one edge, then settle 1 ns past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic send(input logic [NW-1:0] n, input logic [DW-1:0] d, input logic with_beat);
        note = n; duration = d; new_note = 1'b1; beat = with_beat;
        step();
        new_note = 1'b0; beat = 1'b0;
    endtask

    task automatic tick();
        beat = 1'b1;
        step();
        beat = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; play = 1'b1; note = '0; duration = '0; new_note = 1'b0; beat = 1'b0;
        #2;
        total++;
        if ({voice_load, voice_note, voice_active, voice_done, full, dropped} !== '0) begin
            bad++;
            $display("FAIL reset_outputs act=%h exp=0", {voice_load, voice_note, voice_active, voice_done, full, dropped});
        end
        step();
        reset = 1'b0;
    endtask

    task automatic test_single_note();
        send(6'd37, 6'd4, 1'b0);
        total++;
        if (voice_load !== 3'b001) begin bad++; $display("FAIL single_load act=%b exp=001", voice_load); end
        total++;
        if (voice_note[5:0] !== 6'd37) begin bad++; $display("FAIL single_note act=%0d exp=37", voice_note[5:0]); end
        total++;
        if (voice_active !== 3'b001) begin bad++; $display("FAIL single_active act=%b exp=001", voice_active); end
        tick();
        total++;
        if (voice_load !== 3'b000) begin bad++; $display("FAIL single_load_width act=%b exp=000", voice_load); end
        tick(); tick();
        total++;
        if (voice_active !== 3'b001 || voice_done !== 3'b000) begin
            bad++; $display("FAIL single_beat3 act=%b/%b exp=001/000", voice_active, voice_done);
        end
        tick();
        total++;
        if (voice_done !== 3'b001 || voice_active !== 3'b000) begin
            bad++; $display("FAIL single_expire act=%b/%b exp=001/000", voice_done, voice_active);
        end
        step();
        total++;
        if (voice_done !== 3'b000) begin bad++; $display("FAIL single_done_width act=%b exp=000", voice_done); end
        total++;
        if (voice_note[5:0] !== 6'd37) begin bad++; $display("FAIL single_note_hold act=%0d exp=37", voice_note[5:0]); end
    endtask

    task automatic test_chord();
        send(6'd37, 6'd4, 1'b0);
        total++;
        if (voice_load !== 3'b001) begin bad++; $display("FAIL chord_load0 act=%b exp=001", voice_load); end
        send(6'd41, 6'd4, 1'b0);
        total++;
        if (voice_load !== 3'b010) begin bad++; $display("FAIL chord_load1 act=%b exp=010", voice_load); end
        send(6'd44, 6'd4, 1'b0);
        total++;
        if (voice_load !== 3'b100) begin bad++; $display("FAIL chord_load2 act=%b exp=100", voice_load); end
        total++;
        if (full !== 1'b1 || voice_active !== 3'b111) begin bad++; $display("FAIL chord_full act=%b/%b exp=1/111", full, voice_active); end
        total++;
        if (voice_note !== {6'd44, 6'd41, 6'd37}) begin bad++; $display("FAIL chord_notes act=%h exp=%h", voice_note, {6'd44, 6'd41, 6'd37}); end
        tick(); tick(); tick();
        total++;
        if (voice_done !== 3'b000) begin bad++; $display("FAIL chord_early_done act=%b exp=000", voice_done); end
        tick();
        total++;
        if (voice_done !== 3'b111 || voice_active !== 3'b000 || full !== 1'b0) begin
            bad++; $display("FAIL chord_expire act=%b/%b/%b exp=111/000/0", voice_done, voice_active, full);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        send(6'd37, 6'd4, 1'b0);
        send(6'd41, 6'd5, 1'b0);
        send(6'd44, 6'd6, 1'b0);
        send(6'd49, 6'd3, 1'b0);
`ifdef VOICE_STEAL_EN
        total++;
        if (dropped !== 1'b0 || voice_load !== 3'b001) begin bad++; $display("FAIL overflow_steal act=%b/%b exp=0/001", dropped, voice_load); end
        total++;
        if (voice_note !== {6'd44, 6'd41, 6'd49}) begin bad++; $display("FAIL overflow_notes act=%h exp=%h", voice_note, {6'd44, 6'd41, 6'd49}); end
`else
        total++;
        if (dropped !== 1'b1 || voice_load !== 3'b000) begin bad++; $display("FAIL overflow_drop act=%b/%b exp=1/000", dropped, voice_load); end
        total++;
        if (voice_note !== {6'd44, 6'd41, 6'd37} || voice_active !== 3'b111) begin
            bad++; $display("FAIL overflow_state act=%h/%b exp=%h/111", voice_note, voice_active, {6'd44, 6'd41, 6'd37});
        end
`endif
        step();
        total++;
        if (dropped !== 1'b0) begin bad++; $display("FAIL overflow_drop_width act=%b exp=0", dropped); end
    endtask

    task automatic test_pause();
        do_reset();
        send(6'd20, 6'd2, 1'b0);
        play = 1'b0;
        tick(); tick(); tick();
        total++;
        if (voice_active !== 3'b001 || voice_done !== 3'b000) begin bad++; $display("FAIL pause_frozen act=%b/%b exp=001/000", voice_active, voice_done); end
        play = 1'b1;
        tick();
        total++;
        if (voice_active !== 3'b001 || voice_done !== 3'b000) begin bad++; $display("FAIL pause_beat1 act=%b/%b exp=001/000", voice_active, voice_done); end
        tick();
        total++;
        if (voice_done !== 3'b001 || voice_active !== 3'b000) begin bad++; $display("FAIL pause_expire act=%b/%b exp=001/000", voice_done, voice_active); end
    endtask

    task automatic test_collision();
        do_reset();
        send(6'd10, 6'd1, 1'b0);
        send(6'd11, 6'd5, 1'b0);
        send(6'd12, 6'd5, 1'b0);
        send(6'd50, 6'd3, 1'b1);
        total++;
        if (voice_done !== 3'b001 || voice_active !== 3'b110) begin bad++; $display("FAIL collide_expire act=%b/%b exp=001/110", voice_done, voice_active); end
        total++;
        if (dropped !== 1'b1 || voice_load !== 3'b000) begin bad++; $display("FAIL collide_drop act=%b/%b exp=1/000", dropped, voice_load); end
        // v1,v2 now at 4; load v0 with 2 on a beat edge: v1,v2 -> 3, v0 keeps 2
        send(6'd51, 6'd2, 1'b1);
        total++;
        if (voice_load !== 3'b001 || voice_note[5:0] !== 6'd51 || voice_active !== 3'b111) begin
            bad++; $display("FAIL collide_reload act=%b/%0d/%b exp=001/51/111", voice_load, voice_note[5:0], voice_active);
        end
        tick();
        total++;
        if (voice_done !== 3'b000) begin bad++; $display("FAIL collide_full_dur act=%b exp=000", voice_done); end
        tick();
        total++;
        if (voice_done !== 3'b001) begin bad++; $display("FAIL collide_v0_expire act=%b exp=001", voice_done); end
        tick();
        total++;
        if (voice_done !== 3'b110 || voice_active !== 3'b000) begin bad++; $display("FAIL collide_rest_expire act=%b/%b exp=110/000", voice_done, voice_active); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(6'd30, 6'd5, 1'b0);
        send(6'd31, 6'd5, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({voice_load, voice_note, voice_active, voice_done, full, dropped} !== '0) begin
            bad++; $display("FAIL reset_mid act=%h exp=0", {voice_load, voice_note, voice_active, voice_done, full, dropped});
        end
        send(6'd33, 6'd2, 1'b1);
        total++;
        if (voice_load !== 3'b000 || voice_active !== 3'b000 || voice_done !== 3'b000) begin
            bad++; $display("FAIL reset_ignore act=%b/%b/%b exp=000/000/000", voice_load, voice_active, voice_done);
        end
        reset = 1'b0;
        tick();
        total++;
        if (voice_done !== 3'b000) begin bad++; $display("FAIL reset_no_done act=%b exp=000", voice_done); end
    endtask

    task automatic test_zero_duration();
        send(6'd40, 6'd0, 1'b0);
        total++;
        if (voice_load !== 3'b000 || dropped !== 1'b0 || voice_active !== 3'b000) begin
            bad++; $display("FAIL zero_dur act=%b/%b/%b exp=000/0/000", voice_load, dropped, voice_active);
        end
    endtask

    task automatic test_max_duration();
        do_reset();
        send(6'd63, 6'd63, 1'b0);
        for (int i = 0; i < 62; i++) tick();
        total++;
        if (voice_active !== 3'b001 || voice_done !== 3'b000) begin bad++; $display("FAIL maxdur_62 act=%b/%b exp=001/000", voice_active, voice_done); end
        tick();
        total++;
        if (voice_done !== 3'b001 || voice_active !== 3'b000) begin bad++; $display("FAIL maxdur_63 act=%b/%b exp=001/000", voice_done, voice_active); end
    endtask

    initial begin
        test_reset();
        test_single_note();
        test_chord();
        test_overflow();
        test_pause();
        test_collision();
        test_reset_mid();
        test_zero_duration();
        test_max_duration();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
